// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared size codes, FSM states and rw constants for mem_responder.
package mem_responder_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the datapath and mem_responder.
interface mem_responder_if;
  logic mem_enable;
  logic rw;
  logic [1:0] size;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic moc;
  logic err;
  modport master(output mem_enable, rw, size, addr, data_in, input data_out, moc, err);
  modport slave(input mem_enable, rw, size, addr, data_in, output data_out, moc, err);
endinterface

// File: rtl/mem_responder_array.sv
// mem_responder_array: byte-lane RAM; lane 3 is the byte at base (bits 31:24), big-endian, wrapping.
module mem_responder_array #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_BYTES)-1:0] base,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  localparam int AW = $clog2(DEPTH_BYTES);
  logic [7:0] mem [DEPTH_BYTES];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[3-i]) mem[base + AW'(i)] <= wdata[31-8*i -: 8];
  assign rdata = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory responder with moc four-phase handshake.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned accesses on err instead of aligning them down.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, we;
  logic [AW-1:0] a_q, a_n, base;
  logic [1:0] sz_q, sz_n;
  logic rw_q, rw_n, moc_q, moc_n, err_q, err_n, mis, bad, access;
  logic [31:0] d_q, d_n, dout_q, dout_n, rdata, wdata, rd_val;
  assign mis = sz_q[1] ? |a_q[1:0] : sz_q[0] & a_q[0];
  assign bad = ALIGN_EN & mis;
  assign base = sz_q[1] ? {a_q[AW-1:2], 2'b00} : sz_q[0] ? {a_q[AW-1:1], 1'b0} : a_q;
  assign access = state == BUSY && bus.mem_enable && cnt == 4'd0;
  assign we = (access && rw_q == RW_WRITE && !bad) ?
              (sz_q[1] ? 4'b1111 : sz_q[0] ? 4'b1100 : 4'b1000) : 4'b0000;
  assign wdata = sz_q[1] ? d_q : sz_q[0] ? {d_q[15:0], 16'h0} : {d_q[7:0], 24'h0};
  assign rd_val = bad ? 32'h0 : sz_q[1] ? rdata :
                  sz_q[0] ? {16'h0, rdata[31:16]} : {24'h0, rdata[31:24]};
  mem_responder_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk(clk), .base(base), .we(we), .wdata(wdata), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      sz_q <= SIZE_BYTE;
      rw_q <= RW_WRITE;
      d_q <= '0;
      moc_q <= 1'b0;
      err_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      a_q <= a_n;
      sz_q <= sz_n;
      rw_q <= rw_n;
      d_q <= d_n;
      moc_q <= moc_n;
      err_q <= err_n;
      dout_q <= dout_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    a_n = a_q;
    sz_n = sz_q;
    rw_n = rw_q;
    d_n = d_q;
    moc_n = moc_q;
    err_n = err_q;
    dout_n = dout_q;
    case (state)
      IDLE: if (bus.mem_enable) begin
        a_n = bus.addr[AW-1:0];
        sz_n = bus.size;
        rw_n = bus.rw;
        d_n = bus.data_in;
        cnt_n = 4'(WAIT_CYCLES);
        state_n = BUSY;
      end
      BUSY:
        if (!bus.mem_enable) state_n = IDLE;
        else if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else begin
          moc_n = 1'b1;
          err_n = bad;
          dout_n = rw_q == RW_READ ? rd_val : dout_q;
          state_n = DONE;
        end
      DONE: if (!bus.mem_enable) begin
        moc_n = 1'b0;
        err_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.moc = moc_q;
  assign bus.err = err_q;
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random accesses checked against a byte-array reference model.
module tb_mem_responder;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int DEPTH = 1024;
  logic clk = 1'b0, reset = 1'b1;
  bit run = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] rm [DEPTH];
  logic [31:0] last = 32'h0;
  mem_responder_if bus();
  mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 if (run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] q, output logic e, output int lat, output logic mf);
    @(negedge clk);
    bus.mem_enable = 1'b1; bus.rw = r; bus.size = s; bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.addr = $urandom; bus.data_in = $urandom; bus.size = 2'($urandom); bus.rw = ~r;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.moc && lat < 20);
    q = bus.data_out; e = bus.err;
    @(negedge clk); bus.mem_enable = 1'b0;
    @(posedge clk); #1; mf = bus.moc;
  endtask

  task automatic access(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] q);
    logic [31:0] eq;
    logic e, ee, mf;
    int lat, ea, b, n;
    op(r, s, a, d, q, e, lat, mf);
    ea = int'(a % 32'(DEPTH));
    n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    ee = 1'b0;
    eq = last;
    if (ALIGN && ea % n != 0) begin
      ee = 1'b1;
      if (r) begin eq = 32'h0; last = 32'h0; end
    end else begin
      b = ea - ea % n;
      if (r) begin
        eq = 32'h0;
        for (int k = 0; k < n; k++) eq = (eq << 8) | 32'(rm[b+k]);
        last = eq;
      end else
        for (int k = 0; k < n; k++) rm[b+k] = 8'(d >> (8 * (n - 1 - k)));
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, q, eq);
    chk({tag, "_err"}, {31'h0, e}, {31'h0, ee});
    chk({tag, "_moc_fall"}, {31'h0, mf}, 32'h0);
  endtask

  initial begin
    logic [31:0] q;
    int seen, n;
    bus.mem_enable = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.data_in = '0;
    #2;
    chk("reset_moc", {31'h0, bus.moc}, 32'h0);
    chk("reset_data", bus.data_out, 32'h0);
    chk("reset_err", {31'h0, bus.err}, 32'h0);
    #5 run = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i += 4) access(1'b0, 2'b10, 32'(i), 32'h0, "init", q);
    for (int i = 0; i < DEPTH; i++) rm[i] = 8'h0;

    access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, "wr_word10", q);
    access(1'b1, 2'b10, 32'h10, 32'h0, "rd_word10", q);
    chk("rd_word10_const", q, 32'hDEADBEEF);
    access(1'b1, 2'b00, 32'h11, 32'h0, "rd_byte11", q);
    chk("rd_byte11_const", q, 32'h000000AD);
    access(1'b0, 2'b10, 32'h20, 32'h0, "wr_word20", q);
    access(1'b0, 2'b01, 32'h22, 32'h1234, "wr_half22", q);
    access(1'b1, 2'b10, 32'h20, 32'h0, "rd_word20", q);
    chk("rd_word20_const", q, 32'h00001234);
    access(1'b1, 2'b10, 32'h420, 32'h0, "rd_wrap420", q);
    chk("rd_wrap420_const", q, 32'h00001234);

    access(1'b0, 2'b10, 32'h30, 32'h55AA55AA, "wr_word30", q);
    @(negedge clk);
    bus.mem_enable = 1'b1; bus.rw = 1'b0; bus.size = 2'b10; bus.addr = 32'h30; bus.data_in = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk); bus.mem_enable = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.moc) seen++; end
    chk("abort_moc", 32'(seen), 32'h0);
    chk("abort_data", bus.data_out, last);
    access(1'b1, 2'b10, 32'h30, 32'h0, "rd_after_abort", q);
    chk("rd_after_abort_const", q, 32'h55AA55AA);

    access(1'b1, 2'b10, 32'h13, 32'h0, "misaligned_rd", q);
    chk("misaligned_rd_const", q, ALIGN ? 32'h0 : 32'hDEADBEEF);

    @(negedge clk);
    bus.mem_enable = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.addr = 32'h10;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.moc && n < 20);
    chk("pre_reset_moc", {31'h0, bus.moc}, 32'h1);
    chk("pre_reset_data", bus.data_out, 32'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_moc", {31'h0, bus.moc}, 32'h0);
    chk("async_reset_data", bus.data_out, 32'h0);
    chk("async_reset_err", {31'h0, bus.err}, 32'h0);
    bus.mem_enable = 1'b0;
    @(negedge clk) reset = 1'b0;
    last = 32'h0;
    access(1'b1, 2'b00, 32'h10, 32'h0, "post_reset_rd", q);
    chk("post_reset_rd_const", q, 32'h000000DE);

    for (int i = 0; i < 150; i++)
      access(1'($urandom), 2'($urandom), $urandom, $urandom, "random", q);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
